// File: rtl/dht11_frame_sender_pkg.sv
// dht_frame_pkg: state encoding, status codes and frame constants shared by the frame sender.
package dht_frame_pkg;
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_KICK      = 3'd1;
    localparam logic [2:0] S_WAIT_BUSY = 3'd2;
    localparam logic [2:0] S_WAIT_DONE = 3'd3;
    localparam logic [2:0] S_CHECK     = 3'd4;
    localparam logic [2:0] S_SEND      = 3'd5;
    localparam logic [2:0] S_FIN       = 3'd6;
    typedef enum logic [1:0] {ST_OK = 2'd0, ST_CSUM = 2'd1, ST_SENSOR = 2'd2, ST_TIMEOUT = 2'd3} status_e;
    localparam int FRAME_LEN = 6;
    localparam logic [7:0] DEF_HEADER = 8'hAA;
endpackage

// File: rtl/dht11_frame_sender_checksum.sv
// dht_checksum: 8-bit wrap-around sum of the four DHT11 data bytes compared with the sensor checksum.
module dht_checksum (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [7:0] c,
    input  logic [7:0] d,
    input  logic [7:0] check_sum,
    output logic       match
);
    logic [7:0] sum;
    assign sum   = a + b + c + d;
    assign match = sum == check_sum;
endmodule

// File: rtl/dht11_frame_sender.sv
// dht11_frame_sender: drives one DHT11 measurement per request and ships a 6-byte result frame to the UART TX.
module dht11_frame_sender
    import dht_frame_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 100_000_000,
    parameter int          CNT_W          = 27,
    parameter logic [7:0]  HEADER         = DEF_HEADER
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    output logic       dht_en,
    output logic       dht_rst,
    input  logic [7:0] hum_int,
    input  logic [7:0] hum_float,
    input  logic [7:0] temp_int,
    input  logic [7:0] temp_float,
    input  logic [7:0] check_sum,
    input  logic       dht_busy,
    input  logic       dht_error,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       done,
    output logic [1:0] status,
    output logic       idle
);
    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;
    logic             flag;
    logic [7:0]       hi, hf, ti, tf;
    logic [7:0]       frame_byte;
    logic             match;
    logic             timeout;

    dht_checksum u_csum (
        .a(hum_int), .b(hum_float), .c(temp_int), .d(temp_float),
        .check_sum(check_sum), .match(match)
    );

    assign timeout    = cnt == CNT_W'(TIMEOUT_CYCLES - 1);
    assign frame_byte = idx == 3'd0 ? HEADER :
                        idx == 3'd1 ? {6'b0, status} :
                        idx == 3'd2 ? hi :
                        idx == 3'd3 ? hf :
                        idx == 3'd4 ? ti : tf;

    // Outputs are registered from the state being entered, so they are glitch-free and match the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            idx      <= '0;
            flag     <= 1'b0;
            {hi, hf, ti, tf} <= '0;
            dht_en   <= 1'b0;
            dht_rst  <= 1'b0;
            tx_valid <= 1'b0;
            tx_data  <= '0;
            done     <= 1'b0;
            status   <= ST_OK;
            idle     <= 1'b1;
        end else begin
            dht_en <= 1'b1;
            done   <= 1'b0;
            case (state)
                S_IDLE: begin
                    dht_rst <= 1'b1;
                    idle    <= 1'b1;
                    if (req) begin
                        state   <= S_KICK;
                        dht_rst <= 1'b0;
                        idle    <= 1'b0;
                    end
                end
                S_KICK: begin
                    cnt   <= '0;
                    flag  <= 1'b0;
                    state <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (dht_busy) begin
                        cnt   <= '0;
                        state <= S_WAIT_DONE;
                    end else if (timeout) begin
                        status   <= ST_TIMEOUT;
                        {hi, hf, ti, tf} <= '0;
                        idx      <= '0;
                        tx_valid <= 1'b1;
                        tx_data  <= HEADER;
                        state    <= S_SEND;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_WAIT_DONE: begin
                    if (dht_error) flag <= 1'b1;
                    if (!dht_busy) begin
                        state <= S_CHECK;
                    end else if (timeout) begin
                        // A stuck busy after an error is reported as a sensor error rather than a plain timeout.
                        status   <= (flag || dht_error) ? ST_SENSOR : ST_TIMEOUT;
                        {hi, hf, ti, tf} <= '0;
                        idx      <= '0;
                        tx_valid <= 1'b1;
                        tx_data  <= HEADER;
                        state    <= S_SEND;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_CHECK: begin
                    status   <= flag ? ST_SENSOR : match ? ST_OK : ST_CSUM;
                    {hi, hf, ti, tf} <= flag ? 32'h0 : {hum_int, hum_float, temp_int, temp_float};
                    idx      <= '0;
                    tx_valid <= 1'b1;
                    tx_data  <= HEADER;
                    state    <= S_SEND;
                end
                S_SEND: begin
                    if (tx_valid && tx_ready) begin
                        tx_valid <= 1'b0;
                        if (idx == 3'(FRAME_LEN - 1)) begin
                            done  <= 1'b1;
                            state <= S_FIN;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else if (!tx_valid) begin
                        tx_valid <= 1'b1;
                        tx_data  <= frame_byte;
                    end
                end
                S_FIN: begin
                    dht_rst <= 1'b1;
                    idle    <= 1'b1;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dht11_frame_sender.sv
// tb_dht11_frame_sender: directed scenarios against a queue-based frame model with a per-cycle output checker.
module tb_dht11_frame_sender;
    localparam int TO = 1000;

    logic       clk = 1'b0, rst = 1'b1, req = 1'b0;
    logic       dht_en, dht_rst, tx_valid, done, idle;
    logic [7:0] hum_int = 8'h0, hum_float = 8'h0, temp_int = 8'h0, temp_float = 8'h0, check_sum = 8'h0;
    logic       dht_busy = 1'b0, dht_error = 1'b0, tx_ready = 1'b1;
    logic [7:0] tx_data;
    logic [1:0] status;

    always #5 clk = ~clk;

    dht11_frame_sender #(.TIMEOUT_CYCLES(TO), .CNT_W(27), .HEADER(8'hAA)) dut (
        .clk(clk), .rst(rst), .req(req), .dht_en(dht_en), .dht_rst(dht_rst),
        .hum_int(hum_int), .hum_float(hum_float), .temp_int(temp_int), .temp_float(temp_float),
        .check_sum(check_sum), .dht_busy(dht_busy), .dht_error(dht_error),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .done(done), .status(status), .idle(idle)
    );

    int checks = 0, errors = 0, cyc = 0, hs_cnt = 0, done_cnt = 0, first_valid_cyc = -1;
    logic [7:0] exp_q[$];
    logic [7:0] rx[$];
    logic [1:0] exp_status = 2'd0;
    bit rand_ready = 1'b0, arm = 1'b0, prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
        #1;
        tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

    initial forever begin
        @(negedge clk);
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid_held", tx_valid, 1);
                check("stall_data_held", tx_data, prev_data);
            end
            if (arm && tx_valid) begin
                first_valid_cyc = cyc;
                arm = 1'b0;
            end
            if (tx_valid && tx_ready) begin
                hs_cnt++;
                rx.push_back(tx_data);
                if (exp_q.size() == 0) check("byte_expected", 0, 1);
                else check("tx_byte", tx_data, exp_q.pop_front());
            end
            if (done) begin
                done_cnt++;
                check("done_status", status, exp_status);
                check("done_all_sent", exp_q.size(), 0);
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
        end
    end

    // mode 0: normal read, 1: error pulse with busy stuck high, 2: sensor never answers
    task automatic start_frame(input int mode, input logic [7:0] a, b, c, d, cs, output int mark);
        logic [7:0] s;
        logic [1:0] st;
        s  = a + b + c + d;
        st = mode == 1 ? 2'd2 : mode == 2 ? 2'd3 : (s == cs ? 2'd0 : 2'd1);
        exp_status = st;
        exp_q.push_back(8'hAA);
        exp_q.push_back({6'b0, st});
        for (int i = 0; i < 4; i++) exp_q.push_back(mode == 0 ? (i == 0 ? a : i == 1 ? b : i == 2 ? c : d) : 8'h00);
        rx.delete();
        first_valid_cyc = -1;
        mark = 0;
        @(negedge clk);
        req = 1'b1;
        if (mode == 2) begin
            mark = cyc;
            arm  = 1'b1;
        end
        @(negedge clk);
        req = 1'b0;
        if (mode != 2) begin
            repeat (4) @(negedge clk);
            {hum_int, hum_float, temp_int, temp_float, check_sum} = {a, b, c, d, cs};
            dht_busy = 1'b1;
            if (mode == 1) begin
                mark = cyc;
                arm  = 1'b1;
                repeat (3) @(negedge clk);
                dht_error = 1'b1;
                @(negedge clk);
                dht_error = 1'b0;
            end else begin
                repeat (20) @(negedge clk);
                dht_busy = 1'b0;
                mark = cyc;
                arm  = 1'b1;
            end
        end
    endtask

    task automatic finish_frame(input int d0, input int h0, input int mark, input int lat, input bit poke);
        int n = 0;
        while (done_cnt == d0 && n < 5000) begin
            @(negedge clk);
            #1;
            req = poke && tx_valid && (n % 3 == 0);
            n++;
        end
        req = 1'b0;
        check("done_seen", done_cnt != d0, 1);
        check("first_valid_latency", first_valid_cyc - mark, lat);
        @(negedge clk);
        check("idle_after_done", idle, 1);
        check("dht_rst_after_done", dht_rst, 1);
        check("dht_en_after_done", dht_en, 1);
        dht_busy = 1'b0;
        repeat (5) @(negedge clk);
        check("single_done", done_cnt, d0 + 1);
        check("handshakes", hs_cnt - h0, 6);
        check("still_idle", idle, 1);
        check("no_valid_idle", tx_valid, 0);
    endtask

    initial begin
        int d0, h0, mark, n;
        req = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_dht_en", dht_en, 0);
        check("rst_dht_rst", dht_rst, 0);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_done", done, 0);
        check("rst_status", status, 0);
        check("rst_idle", idle, 1);
        rst = 1'b0;
        req = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_after_rst", idle, 1);
        check("idle_dht_en", dht_en, 1);
        check("idle_dht_rst", dht_rst, 1);

        d0 = done_cnt; h0 = hs_cnt;
        start_frame(0, 8'h37, 8'h00, 8'h19, 8'h00, 8'h50, mark);
        finish_frame(d0, h0, mark, 2, 1'b0);
        check("good_status", status, 0);
        check("good_rx2", rx[2], 8'h37);
        check("good_rx4", rx[4], 8'h19);

        d0 = done_cnt; h0 = hs_cnt;
        start_frame(0, 8'h37, 8'h00, 8'h19, 8'h00, 8'h51, mark);
        finish_frame(d0, h0, mark, 2, 1'b0);
        check("csum_status", status, 1);
        check("csum_rx1", rx[1], 8'h01);

        d0 = done_cnt; h0 = hs_cnt;
        start_frame(1, 8'h37, 8'h00, 8'h19, 8'h00, 8'h50, mark);
        finish_frame(d0, h0, mark, TO + 1, 1'b0);
        check("err_status", status, 2);
        check("err_rx2_zero", rx[2], 8'h00);

        d0 = done_cnt; h0 = hs_cnt;
        start_frame(2, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, mark);
        finish_frame(d0, h0, mark, TO + 2, 1'b0);
        check("noresp_status", status, 3);
        check("noresp_rx1", rx[1], 8'h03);

        rand_ready = 1'b1;
        d0 = done_cnt; h0 = hs_cnt;
        start_frame(0, 8'h12, 8'h34, 8'h56, 8'h78, 8'h14, mark);
        finish_frame(d0, h0, mark, 2, 1'b1);
        check("bp_status", status, 0);
        check("bp_rx5", rx[5], 8'h78);
        rand_ready = 1'b0;

        d0 = done_cnt; h0 = hs_cnt;
        start_frame(0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFC, mark);
        finish_frame(d0, h0, mark, 2, 1'b0);
        check("wrap_status", status, 0);

        d0 = done_cnt; h0 = hs_cnt;
        start_frame(0, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0B, mark);
        n = 0;
        while (hs_cnt < h0 + 3 && n < 500) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("reached_byte3", hs_cnt - h0, 3);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_tx_valid", tx_valid, 0);
        check("abort_idle", idle, 1);
        check("abort_done", done, 0);
        rst = 1'b0;
        exp_q.delete();
        exp_status = 2'd0;
        repeat (20) @(negedge clk);
        check("abort_no_done", done_cnt, d0);
        check("abort_no_more_bytes", hs_cnt - h0, 3);
        check("abort_status_cleared", status, 0);
        check("abort_idle_later", idle, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
